// File: rtl/drone_pkg.sv
// Shared types and constants for the drone motor-sensing path: RPM word type,
// motor index order, gate sequencer states and the RPM clamp helper.
package drone_pkg;

  localparam logic [15:0] RPM_MAX = 16'h157C;

  typedef shortint rpm_t;

  typedef enum logic [1:0] {
    MOT_L  = 2'd0,
    MOT_RT = 2'd1,
    MOT_F  = 2'd2,
    MOT_RV = 2'd3
  } mot_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } gate_state_e;

  function automatic logic [15:0] clamp_rpm(input logic [31:0] product);
    return (product > 32'(RPM_MAX)) ? RPM_MAX : product[15:0];
  endfunction

endpackage

// File: rtl/tach_chan.sv
// One tach channel: synchronizer, armed edge detect, saturating pulse counter,
// scale/clamp to RPM and stall tracking. Averaging when RPM_TACH_AVG_EN is defined.
module tach_chan
  import drone_pkg::*;
#(
  parameter int RPM_PER_PULSE = 10,
  parameter int STALL_GATES   = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic tach,
  input  logic armed,
  input  logic terminal,
  output rpm_t rpm,
  output logic stall
);

  localparam int ZW = $clog2(STALL_GATES + 1);

  logic          sync1, sync2, sync2_d, edge_q;
  logic [15:0]   pulse_cnt, snap, cur, result;
  logic [31:0]   product;
  logic [ZW-1:0] zero_cnt, zero_nx;

  always_comb begin
    snap = pulse_cnt;
    if (edge_q && pulse_cnt != 16'hFFFF) snap = pulse_cnt + 16'd1;
    product = 32'(snap) * 32'(RPM_PER_PULSE);
    cur     = clamp_rpm(product);
    zero_nx = '0;
    if (snap == 16'd0)
      zero_nx = (zero_cnt == ZW'(STALL_GATES)) ? zero_cnt : zero_cnt + ZW'(1);
  end

`ifdef RPM_TACH_AVG_EN
  logic [15:0] prev;
  logic [16:0] sum;
  assign sum    = {1'b0, cur} + {1'b0, prev};
  assign result = 16'(sum >> 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       prev <= '0;
    else if (terminal) prev <= cur;
  end
`else
  assign result = cur;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync2_d   <= 1'b0;
      edge_q    <= 1'b0;
      pulse_cnt <= '0;
      zero_cnt  <= '0;
      stall     <= 1'b0;
      rpm       <= '0;
    end else begin
      sync1   <= tach;
      sync2   <= sync1;
      // While disarmed the history flop preloads the value sync2 is about to take,
      // so a line already high at reset release never looks like a rising edge.
      sync2_d <= armed ? sync2 : sync1;
      edge_q  <= armed & sync2 & ~sync2_d;
      if (terminal) begin
        pulse_cnt <= '0;
        zero_cnt  <= zero_nx;
        stall     <= (zero_nx == ZW'(STALL_GATES));
        rpm       <= rpm_t'(result);
      end else if (edge_q && pulse_cnt != 16'hFFFF) begin
        pulse_cnt <= pulse_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/rpm_tach.sv
// Multi-channel tachometer: shared gate timer and arm sequencer feeding one
// tach_chan per motor. Optional output averaging via macro RPM_TACH_AVG_EN.
module rpm_tach
  import drone_pkg::*;
#(
  parameter int NUM_MOT       = 4,
  parameter int GATE_CYCLES   = 4000,
  parameter int RPM_PER_PULSE = 10,
  parameter int STALL_GATES   = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_MOT-1:0] tach_in,
  output rpm_t               rpm_sense [NUM_MOT-1:0],
  output logic               rpm_valid,
  output logic [NUM_MOT-1:0] stall,
  output gate_state_e        dbg_state
);

  localparam int GW = $clog2(GATE_CYCLES);

  gate_state_e   state, state_nx;
  logic [GW-1:0] gate_cnt;
  logic          armed, terminal;

  assign dbg_state = state;
  assign armed     = (state == ST_COUNT);
  assign terminal  = armed && (gate_cnt == GW'(GATE_CYCLES - 1));

  // IDLE and ARM each hold one cycle after release while the synchronizers fill.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = ST_ARM;
      ST_ARM:  state_nx = ST_COUNT;
      default: state_nx = ST_COUNT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gate_cnt  <= '0;
      rpm_valid <= 1'b0;
    end else begin
      rpm_valid <= terminal;
      if (armed) gate_cnt <= terminal ? '0 : gate_cnt + GW'(1);
    end
  end

  for (genvar i = 0; i < NUM_MOT; i++) begin : g_chan
    tach_chan #(
      .RPM_PER_PULSE(RPM_PER_PULSE),
      .STALL_GATES  (STALL_GATES)
    ) u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .tach    (tach_in[i]),
      .armed   (armed),
      .terminal(terminal),
      .rpm     (rpm_sense[i]),
      .stall   (stall[i])
    );
  end

endmodule

// File: tb/tb_rpm_tach.sv
// Directed bench for rpm_tach: per-gate expected results are queued when the
// stimulus is set up and popped on every rpm_valid strobe.
module tb_rpm_tach;
  import drone_pkg::*;

  localparam int NUM_MOT = 4;
  localparam int GATE    = 4000;
  localparam int W       = 4 + 64 + 4;  // {skip mask, rpm ch3..ch0, stall}

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic [NUM_MOT-1:0] tach_in = '0;
  rpm_t               rpm_sense [NUM_MOT-1:0];
  logic               rpm_valid;
  logic [NUM_MOT-1:0] stall;
  gate_state_e        dbg_state;

  rpm_tach #(
    .NUM_MOT(NUM_MOT), .GATE_CYCLES(GATE), .RPM_PER_PULSE(10), .STALL_GATES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .tach_in(tach_in), .rpm_sense(rpm_sense),
    .rpm_valid(rpm_valid), .stall(stall), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  int   period [NUM_MOT];
  logic level  [NUM_MOT];
  int   ph     [NUM_MOT];
  int   since_rel = 0;
  int   strobes = 0;
  int   last_strobe = 0;
  bit   first_pending = 1'b0;

  function automatic logic [W-1:0] mk(input logic [3:0] skip, input int r0, input int r1,
                                      input int r2, input int r3, input logic [3:0] st);
    return {skip, 16'(r3), 16'(r2), 16'(r1), 16'(r0), st};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_MOT; i++)
      tach_in[i] = (period[i] == 0) ? level[i] : ((ph[i] % period[i]) < (period[i] / 2));
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < NUM_MOT; i++) begin
      logic [15:0] r;
      r = rpm_sense[i];
      check($sformatf("%s_rpm%0d", tag, i), 32'(r), 32'd0);
    end
    check({tag, "_valid"}, 32'(rpm_valid), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // One clock: sample outputs on the falling edge, score any strobe, then advance stimulus.
  task automatic step();
    logic [W-1:0] e;
    logic [15:0]  r;
    @(negedge clk);
    since_rel++;
    if (rpm_valid) begin
      strobes++;
      if (first_pending) check("first_strobe_latency", 32'(since_rel), 32'(GATE + 2));
      else               check("strobe_interval", 32'(since_rel - last_strobe), 32'(GATE));
      first_pending = 1'b0;
      last_strobe   = since_rel;
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NUM_MOT; i++) begin
          if (!e[68 + i]) begin
            r = rpm_sense[i];
            check($sformatf("strobe%0d_rpm%0d", strobes, i), 32'(r), 32'(e[4 + 16*i +: 16]));
          end
        end
        check($sformatf("strobe%0d_stall", strobes), 32'(stall), 32'(e[3:0]));
      end
    end
    for (int i = 0; i < NUM_MOT; i++) ph[i]++;
    drive();
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_strobes(input int n);
    int target;
    int budget;
    target = strobes + n;
    budget = n * GATE + 50;
    while (strobes < target && budget > 0) begin
      step();
      budget--;
    end
    check("strobe_count", 32'(strobes), 32'(target));
  endtask

  task automatic do_release();
    for (int i = 0; i < NUM_MOT; i++) ph[i] = 0;
    drive();
    resetn        = 1'b1;
    since_rel     = 0;
    first_pending = 1'b1;
  endtask

  initial begin
    // Lines held high through reset release must never count.
    for (int i = 0; i < NUM_MOT; i++) begin period[i] = 0; level[i] = 1'b1; end
    drive();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    do_release();
    exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000));
    exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b1111));
    run_strobes(2);
    check("queue_drained_t1", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-gate: outputs clear before the next clock edge.
    run_steps(1000);
    resetn = 1'b0;
    #1;
    check_reset("mid_gate");

    // Steady, stalled and overspeed channels; ch1 then starts turning.
    period[MOT_L] = 8; period[MOT_RT] = 0; level[MOT_RT] = 1'b0;
    period[MOT_F] = 4; period[MOT_RV] = 8;
    run_steps(2);
    do_release();
    exp_q.push_back(mk(4'b1001, 0, 0, 5500, 0, 4'b0000));
    exp_q.push_back(mk(4'b0000, 5000, 0, 5500, 5000, 4'b0010));
    exp_q.push_back(mk(4'b0000, 5000, 0, 5500, 5000, 4'b0010));
    run_strobes(3);
    period[MOT_RT] = 8; ph[MOT_RT] = 0;
    drive();
    exp_q.push_back(mk(4'b0010, 5000, 0, 5500, 5000, 4'b0000));
    exp_q.push_back(mk(4'b0000, 5000, 5000, 5500, 5000, 4'b0000));
    run_strobes(2);
    check("queue_drained_t2", 32'(exp_q.size()), 32'd0);

    // Single edge detected in the terminal cycle belongs to the closing gate.
    resetn = 1'b0;
    for (int i = 0; i < NUM_MOT; i++) begin period[i] = 0; level[i] = 1'b0; end
    drive();
    run_steps(2);
    do_release();
    exp_q.push_back(mk(4'b0000, 10, 0, 0, 0, 4'b0000));
    exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b1110));
    run_steps(GATE - 2);
    level[MOT_L] = 1'b1;
    drive();
    run_strobes(2);
    check("queue_drained_t3", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
